cla_mp_add_seq: RTL and testbench

Multi-precision add/subtract sequencer. It time-shares one N-bit carry-lookahead adder slice (CLA_N_bit) across WORDS operand words, one word per clock, least significant word first. The carry is held in a register between cycles. It produces an N*WORDS-bit result with carry and signed-overflow flags. Command input and result output each use a valid/ready handshake, so the block sits between a register-file/operand source and a result consumer.

---
 rtl/cla_mp_add_seq.sv | 176 +++++++++++++++++
 tb/tb_cla_mp_add_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_mp_add_seq.sv
// ---------------------------------------------------------------------------
// cla_mp_add_seq -- multi-precision add/subtract sequencer.
//
// One N-bit carry-lookahead slice (cla_n_bit) is shared across WORDS operand
// words. The block processes one word per clock, least significant word first.
// The carry is kept in a register between words. Subtraction is done as
// A + ~B + 1: B is inverted when it is latched, and the carry is seeded with 1.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start_valid/ready     command handshake; sub, op_a, op_b sampled on accept
//   res_valid/ready       result handshake
//   result                N*WORDS-bit sum or difference
//   cout                  carry out of the MSB (subtract: 1 = no borrow)
//   ovf                   two's-complement signed overflow
//   zero                  result == 0
// ---------------------------------------------------------------------------

// N-bit carry-lookahead adder slice. Every carry is computed as a flat
// sum-of-products over the generate/propagate terms, not as a ripple chain.
module cla_n_bit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  always_comb begin
    logic term;
    logic acc;
    // NOTE: every variable written here gets a default before any
    // conditional use; otherwise synthesis infers a latch.
    c    = '0;
    term = 1'b0;
    acc  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      term = cin;
      for (int k = 0; k <= i; k++) term = term & p[k];
      acc = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];
endmodule

module cla_mp_add_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4,
  parameter int IW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic                 sub,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N*WORDS-1:0]   result,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero
);
  localparam int W = N * WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;  // already inverted when the command is a subtract
  logic           carry;
  logic [IW-1:0]  idx;

  logic [N-1:0]   s_a;
  logic [N-1:0]   s_b;
  logic [N-1:0]   s_sum;
  logic           s_cout;
  logic           last;

  assign s_a  = a_reg[idx*N +: N];
  assign s_b  = b_reg[idx*N +: N];
  assign last = (idx == IW'(WORDS - 1));

  cla_n_bit #(.N(N)) u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    if (!rst_n) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      result      <= '0;
      cout        <= 1'b0;
      ovf         <= 1'b0;
      zero        <= 1'b0;
      idx         <= '0;
      carry       <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_reg       <= op_a;
            b_reg       <= sub ? ~op_b : op_b;
            carry       <= sub;  // +1 of the two's-complement negate
            idx         <= '0;
            start_ready <= 1'b0;
            state       <= RUN;
          end
        end

        RUN: begin
          result[idx*N +: N] <= s_sum;
          carry              <= s_cout;
          idx                <= idx + 1'b1;
          if (last) begin
            state     <= DONE;
            res_valid <= 1'b1;
            cout      <= s_cout;
            // The sign bits come from the stored operands. For a subtract,
            // b_reg already holds ~B, so the add-overflow rule applies.
            ovf       <= (a_reg[W-1] == b_reg[W-1]) && (s_sum[N-1] != a_reg[W-1]);
            // The lower words are already final in result; the top word is
            // still being written, so the fresh sum is used for it.
            zero      <= (result[(WORDS-1)*N-1:0] == '0) && (s_sum == '0);
          end
        end

        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          res_valid   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cla_mp_add_seq.sv
// ---------------------------------------------------------------------------
// tb_cla_mp_add_seq -- self-checking bench for cla_mp_add_seq (N=4, WORDS=4).
// A driver issues commands and pushes the expected response, computed with
// plain integer arithmetic, into a queue. A monitor pops and compares each
// presented result, and also checks latency, hold stability and start_ready.
// ---------------------------------------------------------------------------
module tb_cla_mp_add_seq;
  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int IW    = 2;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  cla_mp_add_seq #(.N(N), .WORDS(WORDS), .IW(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .sub         (sub),
    .op_a        (op_a),
    .op_b        (op_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .ovf         (ovf),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
    int           acc;  // cycle number of the accept edge
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   rr_mode  = 1'b0;  // 0: res_ready = rr_force, 1: random
  bit   rr_force = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: the operands are treated as plain integers.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    longint ua, ub, ur;
    longint sa, sb, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    if (s) begin
      ur  = ua - ub;
      sr  = sa - sb;
      e.c = (ua >= ub);
    end else begin
      ur  = ua + ub;
      sr  = sa + sb;
      e.c = (ur >= (longint'(1) << W));
    end
    e.r   = W'(ur);
    e.o   = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
    e.z   = (e.r == '0);
    e.acc = 0;
    return e;
  endfunction

  // res_ready driver
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      res_ready = rr_mode ? ($urandom_range(0, 3) != 0) : rr_force;
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  bit           prev_valid = 1'b0;
  bit           hold       = 1'b0;
  bit           sr_pending = 1'b0;
  logic [W-1:0] h_r;
  logic         h_c, h_o, h_z;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      hold       = 1'b0;
      sr_pending = 1'b0;
    end else begin
      if (sr_pending) begin
        check("start_ready_after_handshake", start_ready, 1);
        sr_pending = 1'b0;
      end
      if (res_valid) begin
        check("start_ready_low_in_done", start_ready, 0);
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_res_valid: res_valid=1 with no command outstanding (t=%0t)", $time);
          end else begin
            check("latency", cyc - exp_q[0].acc, WORDS);
          end
        end
        if (hold) begin
          check("hold_result", result, h_r);
          check("hold_flags", {cout, ovf, zero}, {h_c, h_o, h_z});
        end
        if (res_ready) begin
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("result", result, e.r);
            check("cout", cout, e.c);
            check("ovf", ovf, e.o);
            check("zero", zero, e.z);
          end
          sr_pending = 1'b1;
          hold       = 1'b0;
        end else begin
          hold = 1'b1;
          h_r  = result;
          h_c  = cout;
          h_o  = ovf;
          h_z  = zero;
        end
      end
      prev_valid = res_valid;
    end
  end

  // Issue a command, wait (bounded) for it to be accepted, and push the
  // expected response.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   waited = 0;
    start_valid = 1'b1;
    op_a        = a;
    op_b        = b;
    sub         = s;
    forever begin
      @(negedge clk);
      if (start_ready) break;
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 0, 1);
        start_valid = 1'b0;
        return;
      end
    end
    e     = model(a, b, s);
    e.acc = cyc + 1;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    start_valid = 1'b0;
    op_a        = W'($urandom);
    op_b        = W'($urandom);
    sub         = 1'($urandom);
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 || res_valid) begin
      @(negedge clk);
      waited++;
      if (waited > 400) begin
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_start_ready"}, start_ready, 1);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_flags"}, {cout, ovf, zero}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int waited;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    sub         = 1'b0;
    op_a        = '0;
    op_b        = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_values("reset");

    // Directed cases from the plan
    issue(16'hFFFF, 16'h0001, 1'b0);
    drain();
    issue(16'h7FFF, 16'h0001, 1'b0);
    drain();
    issue(16'h0005, 16'h0007, 1'b1);
    drain();
    issue(16'h8000, 16'h0001, 1'b1);
    drain();

    // Back-pressure while start_valid is pulsed with A=0xFFFF during RUN/DONE
    rr_force = 1'b0;
    issue(16'h1234, 16'h1111, 1'b0);
    start_valid = 1'b1;
    op_a        = 16'hFFFF;
    op_b        = 16'h0001;
    sub         = 1'b0;
    waited      = 0;
    while (!res_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("bp_res_valid_seen", res_valid, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    start_valid = 1'b0;
    rr_force    = 1'b1;
    drain();
    repeat (4) @(posedge clk);
    #1;
    check("ignored_cmd_no_result", res_valid, 0);
    check("idle_after_bp", start_ready, 1);

    // Reset in the middle of RUN (idx == 2)
    issue(16'hAAAA, 16'hBBBB, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_values("midrun_reset");
    issue(16'h0001, 16'h0001, 1'b0);
    drain();

    // Randomized traffic under random back-pressure
    rr_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = W'($urandom);
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = 16'h8000;
        2: b = 16'h7FFF;
        default: ;
      endcase
      issue(a, b, 1'($urandom));
    end
    drain();
    rr_mode = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
